// File: rtl/iopmp_pkg.sv
// Shared IOPMP types: access encoding, ERR_CFG view, error record layout and FSM states.
package iopmp_pkg;

  localparam int unsigned IOPMPNumChan    = 2;
  localparam int unsigned SourceWidth     = 8;
  localparam int unsigned ErrAddrWidth    = 34;
  localparam int unsigned ErrIdxWidth     = 9;
  localparam int unsigned ErrDropCntWidth = 8;

  // Width of a channel number; a single channel still needs one bit.
  function automatic int unsigned chan_width(input int unsigned num_chan);
    return (num_chan > 1) ? $clog2(num_chan) : 1;
  endfunction

  localparam int unsigned ErrChanWidth = chan_width(IOPMPNumChan);

  // Zero is reserved so a cleared record never decodes as a real access.
  typedef enum logic [1:0] {
    IOPMP_REQ_NONE  = 2'd0,
    IOPMP_REQ_READ  = 2'd1,
    IOPMP_REQ_WRITE = 2'd2,
    IOPMP_REQ_EXEC  = 2'd3
  } iopmp_req_e;

  typedef struct packed {
    logic ie;
  } err_cfg_t;

  typedef struct packed {
    logic [ErrAddrWidth-1:0] addr;
    iopmp_req_e              access;
    logic [SourceWidth-1:0]  rrid;
    logic [ErrIdxWidth-1:0]  idx;
    logic [ErrChanWidth-1:0] chan;
  } err_record_t;

  typedef enum logic {
    ERR_IDLE     = 1'b0,
    ERR_CAPTURED = 1'b1
  } err_cap_state_e;

endpackage

// File: rtl/iopmp_err_capture_if.sv
// Per-channel violation bundle from the request handler into the error-capture stage.
interface iopmp_err_capture_if
  import iopmp_pkg::*;
#(
  parameter int unsigned NumChan   = IOPMPNumChan,
  parameter int unsigned AddrWidth = ErrAddrWidth,
  parameter int unsigned IdxWidth  = ErrIdxWidth,
  parameter int unsigned RridWidth = SourceWidth
) ();

  logic [NumChan-1:0]   valid;
  logic [AddrWidth-1:0] addr   [NumChan];
  iopmp_req_e           access [NumChan];
  logic [RridWidth-1:0] rrid   [NumChan];
  logic [IdxWidth-1:0]  idx    [NumChan];

  modport master (output valid, addr, access, rrid, idx);
  modport slave  (input  valid, addr, access, rrid, idx);

endinterface

// File: rtl/iopmp_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping, plus request popcount.
module iopmp_rr_arb #(
  parameter int unsigned NumChan = 2,
  parameter int unsigned IdxW    = (NumChan > 1) ? $clog2(NumChan) : 1,
  parameter int unsigned PopW    = $clog2(NumChan + 1)
) (
  input  logic [NumChan-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [IdxW-1:0]    gnt_idx_o,
  output logic               gnt_valid_o,
  output logic [PopW-1:0]    popcnt_o
);

  int unsigned cand;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    popcnt_o    = '0;
    cand        = 0;
    for (int unsigned i = 0; i < NumChan; i++) begin
      popcnt_o = popcnt_o + PopW'(req_i[i]);
    end
    for (int unsigned i = 0; i < NumChan; i++) begin
      cand = (32'(ptr_i) + i) % NumChan;
      if (!gnt_valid_o && req_i[IdxW'(cand)]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/iopmp_err_capture.sv
// Latches the first IOPMP violation into a software-visible record, counts dropped ones, drives the IRQ.
module iopmp_err_capture
  import iopmp_pkg::*;
#(
  parameter int unsigned NumChan   = IOPMPNumChan,
  parameter int unsigned AddrWidth = ErrAddrWidth,
  parameter int unsigned IdxWidth  = ErrIdxWidth,
  parameter int unsigned RridWidth = SourceWidth,
  parameter int unsigned CntWidth  = ErrDropCntWidth,
  localparam int unsigned ChanW    = chan_width(NumChan)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  iopmp_err_capture_if.slave   viol_i,
  input  err_cfg_t             err_cfg_i,
  input  logic                 err_clr_i,
  output logic                 err_valid_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output iopmp_req_e           err_access_o,
  output logic [RridWidth-1:0] err_rrid_o,
  output logic [IdxWidth-1:0]  err_idx_o,
  output logic [ChanW-1:0]     err_chan_o,
  output logic                 err_ovf_o,
  output logic [CntWidth-1:0]  err_drop_cnt_o,
  output logic                 irq_o
);

  localparam int unsigned PopW = $clog2(NumChan + 1);
  localparam int unsigned SumW = CntWidth + 1;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    iopmp_req_e           access;
    logic [RridWidth-1:0] rrid;
    logic [IdxWidth-1:0]  idx;
    logic [ChanW-1:0]     chan;
  } rec_t;

  err_cap_state_e      state_q, state_d;
  rec_t                rec_q, rec_d;
  logic [ChanW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CntWidth-1:0] drop_cnt_q, drop_cnt_d;
  logic                ovf_q, ovf_d;

  logic [ChanW-1:0]    gnt_idx;
  logic                gnt_valid;
  logic [PopW-1:0]     popcnt;

  logic                arb_mode;
  logic [PopW-1:0]     drop_add;
  logic [CntWidth-1:0] cnt_base;
  logic [SumW-1:0]     cnt_sum;

  iopmp_rr_arb #(
    .NumChan (NumChan),
    .IdxW    (ChanW),
    .PopW    (PopW)
  ) u_rr_arb (
    .req_i       (viol_i.valid),
    .ptr_i       (rr_ptr_q),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .popcnt_o    (popcnt)
  );

  // A clear frees the record before this cycle's violations are arbitrated, so both cases behave like IDLE.
  always_comb begin
    state_d    = state_q;
    rec_d      = rec_q;
    rr_ptr_d   = rr_ptr_q;
    arb_mode   = (state_q == ERR_IDLE) || err_clr_i;
    cnt_base   = err_clr_i ? '0 : drop_cnt_q;
    drop_add   = popcnt;
    drop_cnt_d = cnt_base;
    ovf_d      = err_clr_i ? 1'b0 : ovf_q;

    if (err_clr_i) begin
      rec_d   = '0;
      state_d = ERR_IDLE;
    end

    if (arb_mode) begin
      drop_add = gnt_valid ? (popcnt - PopW'(1)) : '0;
      if (gnt_valid) begin
        state_d       = ERR_CAPTURED;
        rec_d.addr    = viol_i.addr[gnt_idx];
        rec_d.access  = viol_i.access[gnt_idx];
        rec_d.rrid    = viol_i.rrid[gnt_idx];
        rec_d.idx     = viol_i.idx[gnt_idx];
        rec_d.chan    = gnt_idx;
        rr_ptr_d      = (gnt_idx == ChanW'(NumChan - 1)) ? '0 : gnt_idx + ChanW'(1);
      end
    end

    cnt_sum = {1'b0, cnt_base} + SumW'(drop_add);
    if (cnt_sum[CntWidth]) begin
      drop_cnt_d = '1;
    end else begin
      drop_cnt_d = cnt_sum[CntWidth-1:0];
    end
    if (drop_add != '0) begin
      ovf_d = 1'b1;
    end
  end

  // NOTE: the record registers are reset too, so software never reads stale data after reset or clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ERR_IDLE;
      rec_q      <= '0;
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      rec_q      <= rec_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign err_valid_o    = (state_q == ERR_CAPTURED);
  assign err_addr_o     = rec_q.addr;
  assign err_access_o   = rec_q.access;
  assign err_rrid_o     = rec_q.rrid;
  assign err_idx_o      = rec_q.idx;
  assign err_chan_o     = rec_q.chan;
  assign err_ovf_o      = ovf_q;
  assign err_drop_cnt_o = drop_cnt_q;
  assign irq_o          = err_valid_o & err_cfg_i.ie;

endmodule

// File: tb/tb_iopmp_err_capture.sv
// Directed self-checking bench for iopmp_err_capture with two channels.
module tb_iopmp_err_capture;
  import iopmp_pkg::*;

  localparam int unsigned NumChan = 2;

  logic        clk;
  logic        rst_n;
  err_cfg_t    err_cfg;
  logic        err_clr;

  logic        err_valid;
  logic [33:0] err_addr;
  iopmp_req_e  err_access;
  logic [7:0]  err_rrid;
  logic [8:0]  err_idx;
  logic [0:0]  err_chan;
  logic        err_ovf;
  logic [7:0]  err_drop_cnt;
  logic        irq;

  int unsigned n_total;
  int unsigned n_pass;

  iopmp_err_capture_if #(.NumChan(NumChan)) viol_if ();

  iopmp_err_capture #(.NumChan(NumChan)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .viol_i         (viol_if),
    .err_cfg_i      (err_cfg),
    .err_clr_i      (err_clr),
    .err_valid_o    (err_valid),
    .err_addr_o     (err_addr),
    .err_access_o   (err_access),
    .err_rrid_o     (err_rrid),
    .err_idx_o      (err_idx),
    .err_chan_o     (err_chan),
    .err_ovf_o      (err_ovf),
    .err_drop_cnt_o (err_drop_cnt),
    .irq_o          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_viol(input int ch, input logic [33:0] a, input iopmp_req_e acc,
                          input logic [7:0] r, input logic [8:0] ix);
    viol_if.valid[ch]  = 1'b1;
    viol_if.addr[ch]   = a;
    viol_if.access[ch] = acc;
    viol_if.rrid[ch]   = r;
    viol_if.idx[ch]    = ix;
  endtask

  task automatic clear_viol();
    viol_if.valid = '0;
    for (int i = 0; i < NumChan; i++) begin
      viol_if.addr[i]   = '0;
      viol_if.access[i] = IOPMP_REQ_NONE;
      viol_if.rrid[i]   = '0;
      viol_if.idx[i]    = '0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, err_valid, 0);
    check({tag, ".addr"}, err_addr, 0);
    check({tag, ".access"}, err_access, 0);
    check({tag, ".rrid"}, err_rrid, 0);
    check({tag, ".idx"}, err_idx, 0);
    check({tag, ".chan"}, err_chan, 0);
    check({tag, ".ovf"}, err_ovf, 0);
    check({tag, ".drop"}, err_drop_cnt, 0);
    check({tag, ".irq"}, irq, 0);
  endtask

  initial begin
    n_total     = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    err_cfg.ie  = 1'b1;
    err_clr     = 1'b0;
    clear_viol();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 rst_n = 1'b1;

    // Single violation on ch0.
    set_viol(0, 34'h1_0000_1000, IOPMP_REQ_WRITE, 8'd3, 9'd5);
    tick();
    clear_viol();
    check("single.valid", err_valid, 1);
    check("single.addr", err_addr, 64'h1_0000_1000);
    check("single.access", err_access, IOPMP_REQ_WRITE);
    check("single.rrid", err_rrid, 3);
    check("single.idx", err_idx, 5);
    check("single.chan", err_chan, 0);
    check("single.irq", irq, 1);
    check("single.drop", err_drop_cnt, 0);
    check("single.ovf", err_ovf, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr1.valid", err_valid, 0);
    check("clr1.irq", irq, 0);

    // Return rr_ptr to 0, then both channels at once.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    set_viol(0, 34'h1_0000_1000, IOPMP_REQ_WRITE, 8'd3, 9'd5);
    set_viol(1, 34'h2_0000_2000, IOPMP_REQ_READ, 8'd4, 9'd6);
    tick();
    clear_viol();
    check("both1.chan", err_chan, 0);
    check("both1.addr", err_addr, 64'h1_0000_1000);
    check("both1.drop", err_drop_cnt, 1);
    check("both1.ovf", err_ovf, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr2.valid", err_valid, 0);
    check("clr2.drop", err_drop_cnt, 0);
    check("clr2.ovf", err_ovf, 0);
    set_viol(0, 34'h1_0000_1000, IOPMP_REQ_WRITE, 8'd3, 9'd5);
    set_viol(1, 34'h2_0000_2000, IOPMP_REQ_READ, 8'd4, 9'd6);
    tick();
    clear_viol();
    check("both2.chan", err_chan, 1);
    check("both2.addr", err_addr, 64'h2_0000_2000);
    check("both2.idx", err_idx, 6);
    check("both2.drop", err_drop_cnt, 1);

    // 300 further violations while the record is held.
    for (int i = 0; i < 100; i++) begin
      set_viol(0, 34'h3_FFFF_0000, IOPMP_REQ_EXEC, 8'hAA, 9'h1FF);
      set_viol(1, 34'h3_FFFF_0004, IOPMP_REQ_EXEC, 8'hBB, 9'h1FE);
      tick();
    end
    check("hold.drop201", err_drop_cnt, 201);
    for (int i = 0; i < 50; i++) begin
      tick();
    end
    clear_viol();
    check("hold.drop_sat", err_drop_cnt, 255);
    check("hold.ovf", err_ovf, 1);
    check("hold.chan", err_chan, 1);
    check("hold.addr", err_addr, 64'h2_0000_2000);
    check("hold.access", err_access, IOPMP_REQ_READ);
    check("hold.rrid", err_rrid, 4);
    check("hold.idx", err_idx, 6);
    tick();
    check("sat.stays", err_drop_cnt, 255);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_all_zero("clr3");

    // Capture ch0, drop one ch1, then clear coincident with a ch1 violation.
    set_viol(0, 34'h0_0000_4000, IOPMP_REQ_EXEC, 8'd1, 9'd2);
    tick();
    clear_viol();
    check("cap3.chan", err_chan, 0);
    check("cap3.idx", err_idx, 2);
    set_viol(1, 34'h0_0000_8000, IOPMP_REQ_READ, 8'd2, 9'd3);
    tick();
    clear_viol();
    check("drop1.drop", err_drop_cnt, 1);
    check("drop1.ovf", err_ovf, 1);
    check("drop1.idx", err_idx, 2);
    err_clr = 1'b1;
    set_viol(1, 34'h2_AAAA_5554, IOPMP_REQ_WRITE, 8'd9, 9'd7);
    tick();
    err_clr = 1'b0;
    clear_viol();
    check("clrcap.valid", err_valid, 1);
    check("clrcap.idx", err_idx, 7);
    check("clrcap.chan", err_chan, 1);
    check("clrcap.addr", err_addr, 64'h2_AAAA_5554);
    check("clrcap.rrid", err_rrid, 9);
    check("clrcap.ovf", err_ovf, 0);
    check("clrcap.drop", err_drop_cnt, 0);

    // Interrupt masking without losing the record.
    err_cfg.ie = 1'b0;
    #1;
    check("ie0.irq", irq, 0);
    check("ie0.valid", err_valid, 1);
    err_cfg.ie = 1'b1;
    #1;
    check("ie1.irq", irq, 1);

    // Build drop_cnt=4, then asynchronous reset between edges.
    set_viol(0, 34'h0_0000_0010, IOPMP_REQ_READ, 8'd5, 9'd1);
    set_viol(1, 34'h0_0000_0020, IOPMP_REQ_READ, 8'd6, 9'd2);
    tick();
    tick();
    clear_viol();
    check("pre_rst.drop", err_drop_cnt, 4);
    check("pre_rst.idx", err_idx, 7);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #2 rst_n = 1'b1;
    set_viol(1, 34'h1_2345_6789, IOPMP_REQ_WRITE, 8'd7, 9'd9);
    tick();
    clear_viol();
    check("post_rst.valid", err_valid, 1);
    check("post_rst.chan", err_chan, 1);
    check("post_rst.addr", err_addr, 64'h1_2345_6789);
    check("post_rst.idx", err_idx, 9);
    check("post_rst.drop", err_drop_cnt, 0);
    check("post_rst.irq", irq, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
